// File: rtl/gate_checker_pkg.sv
// Shared types, vector table and reference gate function for gate_checker.
package gate_checker_pkg;

    localparam int unsigned NUM_VEC   = 4;
    localparam int unsigned VEC_IDX_W = 2;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ERR_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } gc_state_e;

    // One stimulus vector driven to the gate block.
    typedef struct packed {
        logic a;
        logic b;
    } gate_vec_t;

    // One response triple from the gate block.
    typedef struct packed {
        logic g_and;
        logic g_or;
        logic g_not;
    } gate_resp_t;

    // Truth-table order: index 0..3 = (a,b) 00, 01, 10, 11.
    localparam gate_vec_t VEC_TABLE [NUM_VEC] = '{
        gate_vec_t'(2'b00),
        gate_vec_t'(2'b01),
        gate_vec_t'(2'b10),
        gate_vec_t'(2'b11)
    };

    // Reference behaviour of a correct universal-gate block.
    function automatic gate_resp_t gate_expect_fn(input logic a, input logic b);
        gate_resp_t r;
        r.g_and = a & b;
        r.g_or  = a | b;
        r.g_not = ~a;
        return r;
    endfunction

endpackage

// File: rtl/gate_checker_expect.sv
// Combinational expected-response generator for the currently driven vector.
// Ports: a, b (driven vector) -> exp_and, exp_or, exp_not.
module gate_expect
    import gate_checker_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic exp_and,
    output logic exp_or,
    output logic exp_not
);

    gate_resp_t exp_c;

    assign exp_c   = gate_expect_fn(a, b);
    assign exp_and = exp_c.g_and;
    assign exp_or  = exp_c.g_or;
    assign exp_not = exp_c.g_not;

endmodule

// File: rtl/gate_checker.sv
// Truth-table checker for a universal-gate block: drives the four (a,b)
// vectors, waits SETTLE_CYC cycles per vector, then compares and/or/not.
// Ports: clk, rst_n (async active-low); start, abort (run control);
//        resp_and/resp_or/resp_not (DUT responses); drv_a/drv_b (stimulus);
//        busy, done (1-cycle pulse), pass, err_count[3:0], fail_vec[3:0].
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       resp_and,
    input  logic       resp_or,
    input  logic       resp_not,
    output logic       drv_a,
    output logic       drv_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [3:0] fail_vec
);

    // With zero settle cycles each vector goes straight to SAMPLE.
    localparam logic SKIP_SETTLE = (SETTLE_CYC == 0);

    gc_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [VEC_IDX_W-1:0]   idx_q;
    logic                   drv_a_q;
    logic                   drv_b_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [ERR_W-1:0]       err_q;
    logic [NUM_VEC-1:0]     fail_q;

    logic                   exp_and;
    logic                   exp_or;
    logic                   exp_not;
    logic [1:0]             mism_c;
    logic [ERR_W-1:0]       err_sum_c;
    logic                   settle_last_c;
    gate_vec_t              next_vec_c;

    gate_expect u_expect (
        .a       (drv_a_q),
        .b       (drv_b_q),
        .exp_and (exp_and),
        .exp_or  (exp_or),
        .exp_not (exp_not)
    );

    // Mismatching response bits for the vector currently on drv_a/drv_b.
    assign mism_c = 2'(resp_and ^ exp_and) + 2'(resp_or ^ exp_or)
                  + 2'(resp_not ^ exp_not);
    // At most 4 vectors x 3 bits = 12, so 4 bits never wrap.
    assign err_sum_c     = err_q + ERR_W'(mism_c);
    assign settle_last_c = (5'(cnt_q) + 5'd1) == 5'(SETTLE_CYC);
    assign next_vec_c    = VEC_TABLE[idx_q + 2'd1];

    // Run sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            drv_a_q <= 1'b0;
            drv_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q <= SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        drv_a_q <= VEC_TABLE[0].a;
                        drv_b_q <= VEC_TABLE[0].b;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fail_q  <= '0;
                    end
                end
                ST_SETTLE, ST_SAMPLE: begin
                    if (abort) begin
                        // Partial err/fail results are kept for inspection.
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        drv_a_q <= 1'b0;
                        drv_b_q <= 1'b0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (state_q == ST_SETTLE) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (settle_last_c) begin
                            state_q <= ST_SAMPLE;
                        end
                    end else begin
                        err_q <= err_sum_c;
                        if (mism_c != 2'd0) begin
                            fail_q[idx_q] <= 1'b1;
                        end
                        if (idx_q == 2'(NUM_VEC - 1)) begin
                            state_q <= ST_DONE;
                            drv_a_q <= 1'b0;
                            drv_b_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_sum_c == '0);
                        end else begin
                            state_q <= SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
                            idx_q   <= idx_q + 2'd1;
                            cnt_q   <= '0;
                            drv_a_q <= next_vec_c.a;
                            drv_b_q <= next_vec_c.b;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign drv_a     = drv_a_q;
    assign drv_b     = drv_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
